core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports ifu_req_valid (output, 1, fetch request), ifu_req_ready (input, 1, fetch accepted) and ifu_addr (output, 32, fetch address = pc).
REQ-005 SHALL have ports ifu_rsp_valid (input, 1, instruction valid) and ifu_rsp_data (input, 32, instruction word).
REQ-006 SHALL have port inst, output, 32, latched instruction presented to decode, imm decoder and register file.
REQ-007 SHALL have inputs is_load, is_store, wen_dec, illegal (1 each, from the control unit), branch_taken (1) and next_pc (32, branch/jump target from the ALU).
REQ-008 SHALL have ports lsu_req_valid (output, 1), lsu_req_ready (input, 1) and lsu_rsp_valid (input, 1) for the data-memory handshake.
REQ-009 SHALL have outputs rf_wen (1, gated register-file write enable), pc (32), halted (1), state (3, debug encoding) and instret (32, retired-instruction count).

Function
REQ-010 SHALL implement states FETCH, IWAIT, EXEC, MEM, MWAIT, WB and HALT.
REQ-011 FETCH: ifu_req_valid=1; on ifu_req_valid&&ifu_req_ready -> IWAIT; otherwise remain in FETCH with ifu_addr held stable.
REQ-012 ifu_rsp_valid and lsu_rsp_valid SHALL be ignored in every state except IWAIT and MWAIT respectively (memories respond no earlier than one cycle after accept).
REQ-013 IWAIT: on ifu_rsp_valid, inst <= ifu_rsp_data and -> EXEC; inst SHALL then hold stable until the next IWAIT capture.
REQ-014 EXEC (exactly 1 cycle): illegal -> HALT; else is_load||is_store -> MEM; else -> WB.
REQ-015 MEM: lsu_req_valid=1 until lsu_req_ready; then -> MWAIT; MWAIT: on lsu_rsp_valid -> WB (stores and loads alike).
REQ-016 WB (exactly 1 cycle): rf_wen = wen_dec && !is_store; pc <= branch_taken ? next_pc : pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); instret += 1 (wraps); -> FETCH.
REQ-017 In WB, branch_taken with next_pc[1:0]!=0 SHALL cause -> HALT with no pc update, no rf_wen and no instret increment.
REQ-018 rf_wen SHALL be 0 in every state other than WB; ifu_req_valid only in FETCH; lsu_req_valid only in MEM.
REQ-019 HALT: halted=1, all request/enable outputs 0, pc and inst frozen; left only by rst.
REQ-020 Minimum latency per instruction: 4 cycles (ALU op, zero-wait memory); 6 cycles for load/store.
REQ-021 state encoding: FETCH=0, IWAIT=1, EXEC=2, MEM=3, MWAIT=4, WB=5, HALT=7.

Reset
REQ-022 While rst=1 (asynchronously): state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), instret=0, halted=0, rf_wen=0, lsu_req_valid=0.
REQ-023 ifu_req_valid SHALL be 1 from the first rising edge after rst deasserts.
REQ-024 Reset mid-transaction SHALL abandon it; a late response arriving after reset SHALL be ignored per REQ-012.

Structure
REQ-025 State enum, encodings (REQ-021) and NOP constant SHALL live in shared package core_pkg.
REQ-026 The instret counter SHALL be a sub-module retire_counter (enable, 32-bit wrap); the FSM stays in core_sequencer.

Verification
REQ-027 Reset then ALU op (ready=1, rsp next cycle, wen_dec=1): ifu_addr=8000_0000, rf_wen pulses once in cycle 4, pc=8000_0004, instret=1.
REQ-028 Fetch stall: ifu_req_ready=0 for 3 cycles -> ifu_req_valid held, ifu_addr stable, no state change; accepted on cycle 4.
REQ-029 Load with lsu_req_ready delayed 2 and rsp 3 cycles later: rf_wen only in WB; store with wen_dec=1: rf_wen stays 0.
REQ-030 Branch: branch_taken=1, next_pc=8000_0100 -> next ifu_addr=8000_0100; next_pc=8000_0102 -> HALT, halted=1, pc unchanged.
REQ-031 illegal=1 in EXEC -> HALT, no rf_wen, instret unchanged; rst asserted in MWAIT with stray lsu_rsp_valid after -> clean FETCH at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding and constants for the core sequencer
//   Exports: state_t (debug-visible state encoding), NOP, PC_STEP,
//            is_misaligned() helper used by the writeback branch check.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd7
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - 32-bit retired-instruction counter
//   clk      : clock, counts on rising edge
//   rst      : asynchronous active-high reset, clears count
//   i_en     : increment by one this cycle
//   o_count  : current count, wraps modulo 2^32
module retire_counter
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/execute/memory/writeback sequencer
//   clk, rst                      : clock, asynchronous active-high reset
//   ifu_req_valid/ready, ifu_addr : instruction fetch request (address = pc)
//   ifu_rsp_valid, ifu_rsp_data   : instruction fetch response
//   inst                          : latched instruction for decode/imm/regfile
//   is_load, is_store, wen_dec,
//   illegal, branch_taken, next_pc: control-unit and ALU inputs
//   lsu_req_valid/ready,
//   lsu_rsp_valid                 : data-memory handshake
//   rf_wen                        : register-file write enable (WB only)
//   pc, halted, state, instret    : architectural/debug status
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        wen_dec,
  input  logic        illegal,
  input  logic        branch_taken,
  input  logic [31:0] next_pc,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] w_pc_next;
  logic        w_ifu_req_valid;
  logic        w_lsu_req_valid;
  logic        w_rf_wen;
  logic        w_inst_load;
  logic        w_pc_load;
  logic        w_retire;
  logic        w_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Responses are only looked at in their wait states, so a late response
  // from a transaction abandoned by reset is dropped naturally.
  always_comb begin
    w_next_state    = r_state;
    w_ifu_req_valid = 1'b0;
    w_lsu_req_valid = 1'b0;
    w_rf_wen        = 1'b0;
    w_inst_load     = 1'b0;
    w_pc_load       = 1'b0;
    w_retire        = 1'b0;
    w_halted        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          w_next_state = ST_IWAIT;
        end
      end
      ST_IWAIT: begin
        if (ifu_rsp_valid) begin
          w_inst_load  = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (illegal) begin
          w_next_state = ST_HALT;
        end else if (is_load || is_store) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM: begin
        w_lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          w_next_state = ST_MWAIT;
        end
      end
      ST_MWAIT: begin
        if (lsu_rsp_valid) begin
          w_next_state = ST_WB;
        end
      end
      ST_WB: begin
        // A taken branch to a misaligned target faults: nothing retires.
        if (branch_taken && is_misaligned(next_pc)) begin
          w_next_state = ST_HALT;
        end else begin
          w_rf_wen     = wen_dec && !is_store;
          w_pc_load    = 1'b1;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = ST_HALT;
      end
    endcase
  end

  assign w_pc_next = branch_taken ? next_pc : (r_pc + PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_inst <= NOP;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_pc_next;
      end
      if (w_inst_load) begin
        r_inst <= ifu_rsp_data;
      end
    end
  end

  retire_counter u_retire_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_retire),
    .o_count (instret)
  );

  assign ifu_req_valid = w_ifu_req_valid;
  assign ifu_addr      = r_pc;
  assign inst          = r_inst;
  assign lsu_req_valid = w_lsu_req_valid;
  assign rf_wen        = w_rf_wen;
  assign pc            = r_pc;
  assign halted        = w_halted;
  assign state         = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer
module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] inst;
  logic        is_load;
  logic        is_store;
  logic        wen_dec;
  logic        illegal;
  logic        branch_taken;
  logic [31:0] next_pc;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic        rf_wen;
  logic [31:0] pc;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] instret;

  core_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .inst          (inst),
    .is_load       (is_load),
    .is_store      (is_store),
    .wen_dec       (wen_dec),
    .illegal       (illegal),
    .branch_taken  (branch_taken),
    .next_pc       (next_pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rf_wen        (rf_wen),
    .pc            (pc),
    .halted        (halted),
    .state         (state),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] exp_inst;
  bit          exp_halt;
  int          wen_cnt;
  int          cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_data = 0;
    is_load = 0; is_store = 0; wen_dec = 0; illegal = 0;
    branch_taken = 0; next_pc = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  // one clock: sample on the falling edge, then advance past the rising edge
  task automatic tick();
    @(negedge clk);
    if (rf_wen) wen_cnt++;
    check("ifu_valid_only_fetch", {31'b0, ifu_req_valid}, {31'b0, state == 3'd0});
    check("lsu_valid_only_mem",   {31'b0, lsu_req_valid}, {31'b0, state == 3'd3});
    check("halted_only_halt",     {31'b0, halted},        {31'b0, state == 3'd7});
    check("rf_wen_only_wb",       {31'b0, rf_wen && state != 3'd5}, 32'd0);
    check("ifu_addr", ifu_addr, exp_pc);
    check("pc",       pc,       exp_pc);
    check("inst_hold", inst,    exp_inst);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst_state",   {29'b0, state}, 32'd0);
    check("rst_pc",      pc, RST_PC);
    check("rst_inst",    inst, NOPW);
    check("rst_instret", instret, 32'd0);
    check("rst_halted",  {31'b0, halted}, 32'd0);
    check("rst_rf_wen",  {31'b0, rf_wen}, 32'd0);
    check("rst_lsu_v",   {31'b0, lsu_req_valid}, 32'd0);
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    exp_pc = RST_PC; exp_ret = 0; exp_inst = NOPW; exp_halt = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 illegal
  task automatic do_instr(input int kind, input bit wen, input bit br, input logic [31:0] tgt,
                          input int fs, input int id, input int ls, input int ld, input bit abort);
    logic [31:0] word;
    bit          mem;
    int          exp_cyc;
    word = $urandom;
    mem  = (kind == 1) || (kind == 2);
    is_load = (kind == 1); is_store = (kind == 2); illegal = (kind == 3);
    wen_dec = wen; branch_taken = br; next_pc = tgt;
    wen_cnt = 0; cyc = 0;

    ifu_req_ready = 0;
    for (int i = 0; i < fs; i++) begin
      ifu_rsp_valid = 1'($urandom % 2); ifu_rsp_data = $urandom;
      lsu_rsp_valid = 1'($urandom % 2);
      tick();
    end
    ifu_req_ready = 1;
    tick();
    ifu_req_ready = 0; ifu_rsp_valid = 0;
    check("st_iwait", {29'b0, state}, 32'd1);
    for (int i = 0; i < id; i++) begin
      ifu_rsp_data = $urandom; lsu_rsp_valid = 1'($urandom % 2);
      tick();
    end
    ifu_rsp_valid = 1; ifu_rsp_data = word;
    tick();
    exp_inst = word;
    ifu_rsp_valid = 1'($urandom % 2); ifu_rsp_data = $urandom;
    check("st_exec", {29'b0, state}, 32'd2);
    tick();

    if (kind == 3) begin
      exp_halt = 1;
      check("illegal_halt", {29'b0, state}, 32'd7);
      check("illegal_wen", wen_cnt, 0);
      check("illegal_instret", instret, exp_ret);
      return;
    end

    if (mem) begin
      check("st_mem", {29'b0, state}, 32'd3);
      lsu_req_ready = 0;
      for (int i = 0; i < ls; i++) begin
        lsu_rsp_valid = 1'($urandom % 2);
        tick();
      end
      lsu_req_ready = 1;
      tick();
      lsu_req_ready = 0; lsu_rsp_valid = 0;
      check("st_mwait", {29'b0, state}, 32'd4);
      if (abort) begin
        tick();
        do_reset();
        ifu_req_ready = 0; lsu_rsp_valid = 1; ifu_rsp_valid = 1; ifu_rsp_data = $urandom;
        for (int i = 0; i < 3; i++) begin
          tick();
          check("abort_stay_fetch", {29'b0, state}, 32'd0);
        end
        clear_inputs();
        return;
      end
      for (int i = 0; i < ld; i++) tick();
      lsu_rsp_valid = 1;
      tick();
      lsu_rsp_valid = 0;
    end

    check("st_wb", {29'b0, state}, 32'd5);
    lsu_rsp_valid = 1'($urandom % 2);
    tick();
    lsu_rsp_valid = 0; ifu_rsp_valid = 0;

    if (br && tgt[1:0] != 2'b00) begin
      exp_halt = 1;
      check("misalign_halt", {29'b0, state}, 32'd7);
      check("misalign_wen", wen_cnt, 0);
    end else begin
      exp_pc  = br ? tgt : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      exp_cyc = fs + 1 + id + 1 + 1 + (mem ? (ls + 1 + ld + 1) : 0) + 1;
      check("back_to_fetch", {29'b0, state}, 32'd0);
      check("wen_pulses", wen_cnt, (wen && kind != 2) ? 1 : 0);
      check("latency", cyc, exp_cyc);
      check("pc_next", pc, exp_pc);
    end
    check("instret", instret, exp_ret);
  endtask

  task automatic halt_freeze();
    for (int i = 0; i < 4; i++) begin
      ifu_req_ready = 1'($urandom % 2); ifu_rsp_valid = 1'($urandom % 2);
      ifu_rsp_data = $urandom; lsu_req_ready = 1'($urandom % 2);
      lsu_rsp_valid = 1'($urandom % 2); wen_dec = 1; illegal = 1'($urandom % 2);
      tick();
      check("halt_stays", {29'b0, state}, 32'd7);
    end
    check("halt_instret", instret, exp_ret);
    do_reset();
  endtask

  initial begin
    int r, kind;
    bit br;
    logic [31:0] tgt;
    rst = 1;
    clear_inputs();
    exp_pc = RST_PC; exp_ret = 0; exp_inst = NOPW; exp_halt = 0;
    do_reset();

    do_instr(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    check("first_pc", pc, 32'h8000_0004);
    do_instr(0, 0, 0, 32'h0, 3, 0, 0, 0, 0);
    do_instr(1, 1, 0, 32'h0, 0, 0, 2, 2, 0);
    do_instr(2, 1, 0, 32'h0, 0, 1, 1, 1, 0);
    do_instr(0, 1, 1, 32'h8000_0100, 0, 0, 0, 0, 0);
    do_instr(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    do_instr(0, 1, 1, 32'h8000_0102, 0, 0, 0, 0, 0);
    halt_freeze();
    do_instr(3, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    halt_freeze();
    do_instr(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    do_instr(0, 1, 0, 32'h0, 1, 0, 0, 0, 0);
    check("pc_wrap", pc, 32'h0000_0000);
    do_instr(1, 1, 0, 32'h0, 0, 0, 0, 2, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom % 16;
      kind = (r < 8) ? 0 : (r < 11) ? 1 : (r < 15) ? 2 : 3;
      br = ($urandom % 4) == 0;
      tgt = $urandom;
      if (($urandom % 5) != 0) tgt[1:0] = 2'b00;
      do_instr(kind, 1'($urandom % 2), br, tgt, $urandom % 3, $urandom % 3,
               $urandom % 3, $urandom % 3, 0);
      if (exp_halt) halt_freeze();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
